// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N up/down counter with load, clear, wrap/saturate and terminal-count pulse
// Optional step prescaler compiled in with MOD_COUNTER_PRESCALER_EN.
module mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 1
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             saturate,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH:0] END_UP = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE    = (WIDTH + 1)'(1);

    logic           step_ok;
    logic [WIDTH:0] cur;
    logic [WIDTH:0] end_val;
    logic [WIDTH:0] stepped;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] load_clamped;
    logic           step_tc;
    logic           unused_msb;

`ifdef MOD_COUNTER_PRESCALER_EN
    localparam int              DIV_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div;

    assign step_ok = enable && (div == DIV_END);

    // Divider only advances on enabled cycles and restarts whenever count is forced.
    always_ff @(posedge CLOCK_50) begin
        if (Reset || clear || load) begin
            div <= '0;
        end else if (enable) begin
            div <= step_ok ? '0 : div + DIV_W'(1);
        end
    end
`else
    assign step_ok = enable;
`endif

    always_comb begin
        cur          = {1'b0, count};
        load_ext     = {1'b0, load_value};
        load_clamped = (load_ext <= END_UP) ? load_ext : END_UP;
        end_val      = up_down ? END_UP : '0;
        stepped      = cur;
        step_tc      = 1'b0;
        if (cur == end_val) begin
            // At the end value: wrap pulses tc, saturate holds silently.
            if (!saturate) begin
                stepped = up_down ? '0 : END_UP;
                step_tc = 1'b1;
            end
        end else begin
            stepped = up_down ? cur + ONE : cur - ONE;
            step_tc = saturate && (stepped == end_val);
        end
    end

    assign unused_msb = stepped[WIDTH] ^ load_clamped[WIDTH];

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_clamped[WIDTH-1:0];
            tc    <= 1'b0;
        end else if (step_ok) begin
            count <= stepped[WIDTH-1:0];
            tc    <= step_tc;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter for the DE-series board designs; successor to the fixed single-direction counter driven by the board top level. It provides configurable width and modulus, run-time direction, parallel load, synchronous clear, wrap or saturate mode, and a one-cycle terminal-count pulse. It sits between board inputs (switches/keys) and display logic (LEDR, HEX decoders), or chains with other instances via `tc` to build multi-digit counters.

## Interface
- `WIDTH`, 8, width of `count` and `load_value`; 1..32.
- `MODULUS`, 256, count range 0..MODULUS-1; 2..2^WIDTH.
- `PRESCALE`, 1, enabled cycles per count step (only with prescaler compiled in); ≥1.
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  count-step qualifier.
- `up_down`  in  1  1 = count up, 0 = count down.
- `saturate`  in  1  1 = stop at end value, 0 = wrap.
- `clear`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous parallel load.
- `load_value`  in  WIDTH  value for `load`.
- `count`  out  WIDTH  registered count value.
- `tc`  out  1  registered terminal-count pulse.

## Operation
- Priority per edge: `Reset` > `clear` > `load` > step > hold.
- Reset: `count`=0, `tc`=0, prescaler divider=0.
- Clear: `count`=0, `tc`=0, divider=0; ignores `enable`.
- Load: `count` = `load_value` if < MODULUS, else MODULUS-1; `tc`=0; divider=0; ignores `enable`.
- Step occurs when `enable`=1 and (prescaler absent or divider == PRESCALE-1).
- Up step: count<MODULUS-1 → count+1; count==MODULUS-1 → 0 (wrap) or hold (saturate).
- Down step: count>0 → count-1; count==0 → MODULUS-1 (wrap) or hold (saturate).
- End value: MODULUS-1 for up, 0 for down.
- `tc`=1 for exactly one cycle, in the cycle `count` first shows the wrapped value (wrap mode) or first reaches the end value (saturate mode). A saturated counter holding at its end value does not re-pulse `tc`.
- `enable`=0: `count`, divider hold; `tc`=0.
- Changing `up_down` or `saturate` takes effect on the next step; no other state is affected.
- Arithmetic in WIDTH+1 bits internally; `count` never leaves 0..MODULUS-1.

## Timing
- All outputs registered; latency 1 cycle from any control input to `count`/`tc`.
- `tc` coincident with the new `count` value; cascading: feed `tc` into the next stage's `enable` (stage advances one cycle after the lower stage wraps).
- Reset asserted mid-count takes effect at the next edge regardless of other inputs; first step possible in the cycle after `Reset` deasserts.
- Simultaneous `clear`+`load`: clear wins. `load`+`enable`: load wins, no step that cycle.

## Configuration
- `MOD_COUNTER_PRESCALER_EN` defined: internal divider of width max(1,$clog2(PRESCALE)) counts enabled cycles 0..PRESCALE-1 and gates steps; divider holds while `enable`=0, cleared by Reset/clear/load. PRESCALE=1 equals no prescale.
- Not defined: divider absent, `PRESCALE` ignored, step on every enabled cycle.

## Test plan
- WIDTH=4, MODULUS=10, up, wrap, enable=1 for 12 cycles from reset → count 1..9,0,1,2; `tc`=1 only on the cycle count=0.
- Down, wrap from reset, 3 enabled cycles → count 9,8,7; `tc`=1 on the cycle count=9.
- Saturate, up, load_value=7, then 5 enabled cycles → 8,9,9,9,9; `tc`=1 once, on first 9.
- load_value=13 (≥MODULUS) → count=9; clear+load same cycle → count=0; Reset while enable=1 at count=5 → count=0, tc=0 next cycle.
- Toggle enable 1,0,1 at count=3 → 4,4,5; `tc`=0 throughout.
- Macro defined, PRESCALE=3, enable=1 for 9 cycles from reset → count steps on cycles 3,6,9 (1,2,3); load mid-divide restarts the 3-cycle interval.
